// File: rtl/irq_ctrl.sv
// Interrupt dispatch stage: collects timer, SGI and external edge events into a pending
// vector and presents one prioritised, masked request to the core over req/ack.
module irq_ctrl #(
   parameter int IRQ_NUM_POW = 4,
   localparam int N = 1 << IRQ_NUM_POW
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [N-1:0]           irq_en_bi,
   input  logic                   irq_timer_i,
   input  logic                   sgi_req_i,
   input  logic [IRQ_NUM_POW-1:0] sgi_code_bi,
   input  logic [N-1:0]           irq_bi,
   output logic                   irq_req_o,
   output logic [IRQ_NUM_POW-1:0] irq_code_bo,
   input  logic                   irq_ack_i,
   output logic [N-1:0]           pending_bo
);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [IRQ_NUM_POW-1:0] code_q, code_d;
   logic [N-1:0]           pending_q, pending_d;
   logic [N-1:0]           prev_q;
   logic [N-1:0]           rise;
   logic [N-1:0]           set_vec;
   logic [N-1:0]           clr_vec;
   logic [N-1:0]           eligible;
   logic [IRQ_NUM_POW-1:0] winner;

   // All event sources OR into one set vector; history starting at 0 makes a line
   // already high at reset release count as a rising edge.
   always_comb begin
      rise    = irq_bi & ~prev_q;
      set_vec = rise;
      if (irq_timer_i) begin
         set_vec[0] = 1'b1;
      end
      if (sgi_req_i) begin
         set_vec[sgi_code_bi] = 1'b1;
      end
   end

   // Lowest-index eligible line wins; scanning downwards lets the last hit be the lowest.
   always_comb begin
      eligible = pending_q & irq_en_bi;
      winner   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = IRQ_NUM_POW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      clr_vec = '0;
      case (state_q)
         IDLE: begin
            if (|eligible) begin
               state_d = REQ;
               code_d  = winner;
            end
         end
         REQ: begin
            if (irq_ack_i) begin
               state_d          = IDLE;
               clr_vec[code_q]  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A set arriving together with the ack-clear wins so no event is lost.
      pending_d = (pending_q & ~clr_vec) | set_vec;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         code_q    <= '0;
         pending_q <= '0;
         prev_q    <= '0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         pending_q <= pending_d;
         prev_q    <= irq_bi;
      end
   end

   assign irq_req_o   = (state_q == REQ);
   assign irq_code_bo = code_q;
   assign pending_bo  = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed table-driven bench for irq_ctrl, plus hand sequences for masking, edge
// detection and reset during an active request.
module tb_irq_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [15:0] irq_en_bi;
   logic        irq_timer_i;
   logic        sgi_req_i;
   logic [3:0]  sgi_code_bi;
   logic [15:0] irq_bi;
   logic        irq_req_o;
   logic [3:0]  irq_code_bo;
   logic        irq_ack_i;
   logic [15:0] pending_bo;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] en;
      logic        timer;
      logic        sgi;
      logic [3:0]  sgi_code;
      logic [15:0] irq;
      logic        ack;
      logic        exp_req;
      logic [3:0]  exp_code;
      logic [15:0] exp_pend;
   } vec_t;

   vec_t vecs[$];

   irq_ctrl #(.IRQ_NUM_POW(4)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .irq_en_bi   (irq_en_bi),
      .irq_timer_i (irq_timer_i),
      .sgi_req_i   (sgi_req_i),
      .sgi_code_bi (sgi_code_bi),
      .irq_bi      (irq_bi),
      .irq_req_o   (irq_req_o),
      .irq_code_bo (irq_code_bo),
      .irq_ack_i   (irq_ack_i),
      .pending_bo  (pending_bo)
   );

   always #5 clk_i = ~clk_i;

   task automatic add_vec(input logic [15:0] en, input logic timer, input logic sgi,
                          input logic [3:0] sgi_code, input logic [15:0] irq, input logic ack,
                          input logic exp_req, input logic [3:0] exp_code,
                          input logic [15:0] exp_pend);
      vec_t v;
      v.en = en; v.timer = timer; v.sgi = sgi; v.sgi_code = sgi_code; v.irq = irq;
      v.ack = ack; v.exp_req = exp_req; v.exp_code = exp_code; v.exp_pend = exp_pend;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, let one rising edge pass, then settle before sampling.
   task automatic apply_stimulus(input logic [15:0] en, input logic timer, input logic sgi,
                                 input logic [3:0] sgi_code, input logic [15:0] irq,
                                 input logic ack);
      irq_en_bi   = en;
      irq_timer_i = timer;
      sgi_req_i   = sgi;
      sgi_code_bi = sgi_code;
      irq_bi      = irq;
      irq_ack_i   = ack;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_output(input string name, input logic exp_req,
                               input logic [3:0] exp_code, input logic [15:0] exp_pend);
      checks++;
      if (irq_req_o !== exp_req) begin
         failures++;
         $display("[TB] FAIL %s irq_req_o got=%0b want=%0b", name, irq_req_o, exp_req);
      end
      checks++;
      if (pending_bo !== exp_pend) begin
         failures++;
         $display("[TB] FAIL %s pending_bo got=%h want=%h", name, pending_bo, exp_pend);
      end
      if (exp_req) begin
         checks++;
         if (irq_code_bo !== exp_code) begin
            failures++;
            $display("[TB] FAIL %s irq_code_bo got=%0d want=%0d", name, irq_code_bo, exp_code);
         end
      end
   endtask

   task automatic check_count(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   initial begin
      int n_req;
      logic ack_next;

      // Columns: en, timer, sgi, sgi_code, irq, ack | exp_req, exp_code, exp_pend
      add_vec(16'h0001, 1, 0, 4'd0,  16'h0000, 0, 0, 4'd0,  16'h0001); // timer tick
      add_vec(16'h0001, 0, 0, 4'd0,  16'h0000, 0, 1, 4'd0,  16'h0001);
      add_vec(16'h0001, 0, 0, 4'd0,  16'h0000, 0, 1, 4'd0,  16'h0001);
      add_vec(16'h0001, 0, 0, 4'd0,  16'h0000, 1, 0, 4'd0,  16'h0000);
      add_vec(16'h0001, 0, 0, 4'd0,  16'h0000, 0, 0, 4'd0,  16'h0000);
      add_vec(16'h0000, 0, 1, 4'd5,  16'h0000, 0, 0, 4'd0,  16'h0020); // masked SGI
      add_vec(16'h0000, 0, 0, 4'd0,  16'h0000, 0, 0, 4'd0,  16'h0020);
      add_vec(16'h0020, 0, 0, 4'd0,  16'h0000, 0, 1, 4'd5,  16'h0020);
      add_vec(16'h0020, 0, 0, 4'd0,  16'h0000, 1, 0, 4'd0,  16'h0000);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0208, 0, 0, 4'd0,  16'h0208); // priority/hold
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0208, 0, 1, 4'd3,  16'h0208);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h020A, 0, 1, 4'd3,  16'h020A);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h020A, 1, 0, 4'd0,  16'h0202);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h020A, 0, 1, 4'd1,  16'h0202);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h020A, 1, 0, 4'd0,  16'h0200);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h020A, 0, 1, 4'd9,  16'h0200);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h020A, 1, 0, 4'd0,  16'h0000);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0000, 0, 0, 4'd0,  16'h0000);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0080, 0, 0, 4'd0,  16'h0080); // ack/set collision
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0000, 0, 1, 4'd7,  16'h0080);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0080, 1, 0, 4'd0,  16'h0080);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0080, 0, 1, 4'd7,  16'h0080);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0000, 1, 0, 4'd0,  16'h0000);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0000, 0, 0, 4'd0,  16'h0000);
      add_vec(16'h0000, 1, 1, 4'd0,  16'h0001, 0, 0, 4'd0,  16'h0001); // merged sources
      add_vec(16'h0000, 0, 0, 4'd0,  16'h0001, 0, 0, 4'd0,  16'h0001);
      add_vec(16'h0001, 0, 0, 4'd0,  16'h0001, 0, 1, 4'd0,  16'h0001);
      add_vec(16'h0001, 0, 0, 4'd0,  16'h0001, 1, 0, 4'd0,  16'h0000);
      add_vec(16'h0001, 0, 0, 4'd0,  16'h0000, 0, 0, 4'd0,  16'h0000);
      add_vec(16'hFFFF, 0, 1, 4'd12, 16'h0000, 0, 0, 4'd0,  16'h1000); // enable drop in REQ
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0000, 0, 1, 4'd12, 16'h1000);
      add_vec(16'h0000, 0, 0, 4'd0,  16'h0000, 0, 1, 4'd12, 16'h1000);
      add_vec(16'h0000, 0, 0, 4'd0,  16'h0000, 1, 0, 4'd0,  16'h0000);
      add_vec(16'hFFFF, 0, 0, 4'd0,  16'h0000, 1, 0, 4'd0,  16'h0000); // ack in IDLE

      rst_ni = 1'b0;
      apply_stimulus(16'h0000, 0, 0, 4'd0, 16'h0000, 0);
      apply_stimulus(16'hFFFF, 1, 1, 4'd3, 16'h0000, 1);
      check_output("reset", 0, 4'd0, 16'h0000);
      check_count("reset_code", int'(irq_code_bo), 0);
      rst_ni = 1'b1;

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].en, vecs[i].timer, vecs[i].sgi, vecs[i].sgi_code,
                        vecs[i].irq, vecs[i].ack);
         check_output($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_code,
                      vecs[i].exp_pend);
      end

      // Masked SGI must stay pending without a request for a long stretch.
      apply_stimulus(16'h0000, 0, 1, 4'd5, 16'h0000, 0);
      n_req = 0;
      for (int c = 0; c < 20; c++) begin
         apply_stimulus(16'h0000, 0, 0, 4'd0, 16'h0000, 0);
         if (irq_req_o !== 1'b0) n_req++;
      end
      check_count("masked_sgi_no_req", n_req, 0);
      check_output("masked_sgi_pending", 0, 4'd0, 16'h0020);
      apply_stimulus(16'h0020, 0, 0, 4'd0, 16'h0000, 0);
      check_output("masked_sgi_enabled", 1, 4'd5, 16'h0020);
      apply_stimulus(16'h0020, 0, 0, 4'd0, 16'h0000, 1);
      check_output("masked_sgi_ack", 0, 4'd0, 16'h0000);

      // A line held high must dispatch exactly once.
      n_req    = 0;
      ack_next = 1'b0;
      for (int c = 0; c < 12; c++) begin
         apply_stimulus(16'hFFFF, 0, 0, 4'd0, (c < 10) ? 16'h0004 : 16'h0000, ack_next);
         if (irq_req_o === 1'b1) begin
            n_req++;
            check_count("held_line_code", int'(irq_code_bo), 2);
         end
         ack_next = irq_req_o;
      end
      check_count("held_line_requests", n_req, 1);
      check_output("held_line_idle", 0, 4'd0, 16'h0000);

      // Reset while requesting code 4, with line 2 high but masked.
      apply_stimulus(16'h0010, 0, 1, 4'd4, 16'h0004, 0);
      check_output("pre_reset_pending", 0, 4'd0, 16'h0014);
      apply_stimulus(16'h0010, 0, 0, 4'd0, 16'h0004, 0);
      check_output("pre_reset_req", 1, 4'd4, 16'h0014);
      rst_ni = 1'b0;
      apply_stimulus(16'hFFFF, 0, 0, 4'd0, 16'h0004, 0);
      check_output("mid_req_reset", 0, 4'd0, 16'h0000);
      rst_ni   = 1'b1;
      n_req    = 0;
      ack_next = 1'b0;
      for (int c = 0; c < 10; c++) begin
         apply_stimulus(16'hFFFF, 0, 0, 4'd0, 16'h0004, ack_next);
         if (irq_req_o === 1'b1) begin
            n_req++;
            check_count("post_reset_code", int'(irq_code_bo), 2);
         end
         ack_next = irq_req_o;
      end
      check_count("post_reset_requests", n_req, 1);
      check_output("post_reset_idle", 0, 4'd0, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
